// File: rtl/gate_ops_pkg.sv
// Shared opcode/state types and the per-lane gate function used by the
// arbitrated logic unit and by anything that needs to predict its result.
package gate_ops_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_NAND  = 3'd2,
    OP_NOR   = 3'd3,
    OP_XOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_NOTA  = 3'd6,
    OP_PASSA = 3'd7
  } gate_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  // Evaluates one bit lane; every opcode is purely bitwise, so callers apply
  // it across lanes and the function stays independent of operand width.
  function automatic logic gate_eval(input logic [OP_W-1:0] op,
                                     input logic a,
                                     input logic b);
    logic r;
    case (gate_op_t'(op))
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_NAND:  r = ~(a & b);
      OP_NOR:   r = ~(a | b);
      OP_XOR:   r = a ^ b;
      OP_XNOR:  r = ~(a ^ b);
      OP_NOTA:  r = ~a;
      default:  r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches upward from last_grant+1 with wrap.
// No state and no backpressure; the caller decides when the pick is used.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic                       any_req,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic [NUM_REQ-1:0]         winner_oh
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    any_req   = |req;
    winner    = '0;
    winner_oh = '0;
    found     = 1'b0;
    idx       = '0;
    // k runs 1..NUM_REQ so the previous winner is examined last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    if (found) winner_oh[winner] = 1'b1;
  end

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin shared bitwise logic unit: grant 1 edge after req, result 1 edge after grant.
// Requesters hold req/op/a/b until gnt; one operation per 2 cycles, no result backpressure.
module gate_unit_arbiter
  import gate_ops_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [OP_W*NUM_REQ-1:0]  op,
  input  logic [WIDTH*NUM_REQ-1:0] a,
  input  logic [WIDTH*NUM_REQ-1:0] b,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     busy,
  output logic                     rsp_valid,
  output logic [2:0]               rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [CNT_W-1:0]         ops_done
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t       state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] win_q;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result;

  logic             any_req;
  logic [IDX_W-1:0] winner;
  logic [NUM_REQ-1:0] winner_oh;

  logic [OP_W-1:0]  op_arr [NUM_REQ];
  logic [WIDTH-1:0] a_arr  [NUM_REQ];
  logic [WIDTH-1:0] b_arr  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign op_arr[i] = op[OP_W*i +: OP_W];
    assign a_arr[i]  = a[WIDTH*i +: WIDTH];
    assign b_arr[i]  = b[WIDTH*i +: WIDTH];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req        (req),
    .last_grant (last_grant),
    .any_req    (any_req),
    .winner     (winner),
    .winner_oh  (winner_oh)
  );

  always_comb begin
    result = '0;
    for (int i = 0; i < WIDTH; i++) begin
      result[i] = gate_eval(op_q, a_q[i], b_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      win_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      gnt        <= '0;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      ops_done   <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      case (state)
        GRANT: begin
          state     <= RESP;
          busy      <= 1'b1;
          rsp_valid <= 1'b1;
          rsp_id    <= 3'(win_q);
          rsp_data  <= result;
          if (ops_done != {CNT_W{1'b1}}) ops_done <= ops_done + CNT_W'(1);
        end
        // IDLE and RESP arbitrate identically; RESP back-to-back keeps 2-cycle throughput.
        default: begin
          if (any_req) begin
            state      <= GRANT;
            busy       <= 1'b1;
            gnt        <= winner_oh;
            last_grant <= winner;
            win_q      <= winner;
            op_q       <= op_arr[winner];
            a_q        <= a_arr[winner];
            b_q        <= b_arr[winner];
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Directed bench for gate_unit_arbiter: stimulus pushes expected grants and
// responses into queues, an independent negedge monitor pops and compares.
module tb_gate_unit_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int CNT_W   = 16;

  typedef struct packed {
    logic [2:0]       id;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] cnt;
  } rsp_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req;
  logic [3*NUM_REQ-1:0]     op;
  logic [WIDTH*NUM_REQ-1:0] a;
  logic [WIDTH*NUM_REQ-1:0] b;
  logic [NUM_REQ-1:0]       gnt;
  logic                     busy;
  logic                     rsp_valid;
  logic [2:0]               rsp_id;
  logic [WIDTH-1:0]         rsp_data;
  logic [CNT_W-1:0]         ops_done;

  int checks = 0;
  int errors = 0;
  int exp_ops = 0;
  logic [NUM_REQ-1:0] exp_gnt [$];
  rsp_t               exp_rsp [$];

  gate_unit_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op        (op),
    .a         (a),
    .b         (b),
    .gnt       (gnt),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .ops_done  (ops_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] g;
    rsp_t r;
    if (gnt != '0) begin
      if (exp_gnt.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_gnt: got %0h, expected none", gnt);
      end else begin
        g = exp_gnt.pop_front();
        check("gnt", 32'(gnt), 32'(g));
        check("busy_at_gnt", 32'(busy), 32'd1);
      end
    end
    if (rsp_valid) begin
      if (exp_rsp.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got id %0d data %0h, expected none", rsp_id, rsp_data);
      end else begin
        r = exp_rsp.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(r.id));
        check("rsp_data", 32'(rsp_data), 32'(r.data));
        check("ops_done", 32'(ops_done), 32'(r.cnt));
        check("busy_at_rsp", 32'(busy), 32'd1);
      end
    end
  end

  task automatic set_operands(input int id, input logic [2:0] o,
                              input logic [7:0] av, input logic [7:0] bv);
    op[3*id +: 3]     = o;
    a[WIDTH*id +: WIDTH] = av;
    b[WIDTH*id +: WIDTH] = bv;
  endtask

  task automatic expect_op(input int id, input logic [7:0] data);
    exp_gnt.push_back(NUM_REQ'(1) << id);
    exp_ops++;
    exp_rsp.push_back('{id: 3'(id), data: data, cnt: CNT_W'(exp_ops)});
  endtask

  // Waits for n grant pulses. hold=0: each granted requester drops its req;
  // hold=1: all req stay high until the last grant, and spacing is checked.
  task automatic wait_grants(input int n, input bit hold);
    int got = 0;
    int cyc = 0;
    int last = -1;
    while (got < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0) begin
        got++;
        if (hold && last >= 0) check("gnt_spacing", 32'(cyc - last), 32'd2);
        last = cyc;
        if (!hold) req = req & ~gnt;
        else if (got == n) req = '0;
      end
    end
    if (got < n) begin
      checks++; errors++;
      $display("FAIL grant_timeout: got %0d grants, expected %0d", got, n);
      req = '0;
    end
  endtask

  task automatic do_op(input int id, input logic [2:0] o, input logic [7:0] av,
                       input logic [7:0] bv, input logic [7:0] data);
    @(negedge clk);
    set_operands(id, o, av, bv);
    expect_op(id, data);
    req[id] = 1'b1;
    wait_grants(1, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] sweep_exp [8];
    int n;
    sweep_exp = '{8'h88, 8'hEE, 8'h77, 8'h11, 8'h66, 8'h99, 8'h33, 8'hCC};
    rst_n = 1'b0;
    req   = '0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state and idle behaviour
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_gnt", 32'(gnt), 32'd0);
      check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_ops_done", 32'(ops_done), 32'd0);
    end

    // Single AND on requester 0
    do_op(0, 3'd0, 8'hCC, 8'hAA, 8'h88);

    // All opcodes on requester 2
    for (int k = 0; k < 8; k++) do_op(2, 3'(k), 8'hCC, 8'hAA, sweep_exp[k]);

    // Leave last_grant at 3, then hold all four requests
    do_op(3, 3'd4, 8'hF0, 8'hFF, 8'h0F);
    @(negedge clk);
    set_operands(0, 3'd0, 8'hCC, 8'hAA);
    set_operands(1, 3'd1, 8'hCC, 8'hAA);
    set_operands(2, 3'd4, 8'hCC, 8'hAA);
    set_operands(3, 3'd6, 8'hCC, 8'hAA);
    for (int r = 0; r < 2; r++) begin
      expect_op(0, 8'h88);
      expect_op(1, 8'hEE);
      expect_op(2, 8'h66);
      expect_op(3, 8'h33);
    end
    req = 4'hF;
    wait_grants(8, 1'b1);
    repeat (3) @(negedge clk);

    // Wrap-around search after a grant to requester 1
    do_op(1, 3'd1, 8'h0F, 8'hF0, 8'hFF);
    @(negedge clk);
    set_operands(3, 3'd2, 8'hFF, 8'h0F);
    set_operands(1, 3'd3, 8'h0F, 8'h30);
    expect_op(3, 8'hF0);
    expect_op(1, 8'hC0);
    req = 4'b1010;
    wait_grants(2, 1'b0);
    repeat (3) @(negedge clk);

    // Reset during the GRANT cycle discards the operation
    set_operands(0, 3'd0, 8'hFF, 8'hFF);
    exp_gnt.push_back(4'b0001);
    req[0] = 1'b1;
    n = 0;
    while (gnt == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_gnt_seen", 32'(gnt), 32'h1);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_ops = 0;
    for (int i = 0; i < 3; i++) begin
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort_ops_done", 32'(ops_done), 32'd0);
      @(negedge clk);
    end
    check("abort_rsp_data", 32'(rsp_data), 32'd0);

    // Requester 0 has priority again after reset
    set_operands(0, 3'd0, 8'hFF, 8'h55);
    set_operands(2, 3'd7, 8'h5A, 8'h00);
    expect_op(0, 8'h55);
    expect_op(2, 8'h5A);
    req = 4'b0101;
    wait_grants(2, 1'b0);
    repeat (5) @(negedge clk);

    check("gnt_queue_empty", 32'(exp_gnt.size()), 32'd0);
    check("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
